// File: rtl/control_sequencer.sv
// control_sequencer: four-phase microcode sequencer (FETCH, DECODE, EXECUTE, NEXT).
// It fetches a 48-bit word from program ROM at pc and drives register-bank and
// memory controls from it for one EXECUTE cycle. It then branches on the sampled
// ALU zero flag. A HALT state parks the sequencer until reset.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic [47:0] instr,
    input  logic        Z,
    output logic [9:0]  pc,
    output logic [4:0]  Sel_A,
    output logic [5:0]  Sel_B,
    output logic [5:0]  Sel_C,
    output logic        MR,
    output logic        MW,
    output logic [3:0]  aluc,
    output logic        KMux,
    output logic [15:0] K,
    output logic        halted
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        NEXT,
        HALT
    } state_t;

    localparam logic [5:0] SEL_C_NONE = 6'd35;

    localparam logic [1:0] JMP_NONE   = 2'b00;
    localparam logic [1:0] JMP_ALWAYS = 2'b01;
    localparam logic [1:0] JMP_ZERO   = 2'b10;
    localparam logic [1:0] JMP_NZERO  = 2'b11;

    state_t      state;
    logic [47:0] ir;
    logic        z_flag;
    logic        take_jump;
    logic [9:0]  pc_next;
    logic        unused_reserved;

    // A/B bus selects, ALU controls and the constant come straight from IR flops.
    // The buses therefore stay stable outside EXECUTE.
    assign Sel_A = ir[41:37];
    assign Sel_B = ir[36:31];
    assign aluc  = ir[30:27];
    assign KMux  = ir[26];
    assign K     = ir[15:0];

    // Reserved instruction bits are carried in IR but have no function.
    assign unused_reserved = ^ir[20:16];

    // Branch resolution for the NEXT phase, based on the Z flag captured in EXECUTE.
    always_comb begin
        take_jump = 1'b0;
        unique case (ir[23:22])
            JMP_NONE:   take_jump = 1'b0;
            JMP_ALWAYS: take_jump = 1'b1;
            JMP_ZERO:   take_jump = z_flag;
            JMP_NZERO:  take_jump = !z_flag;
            default:    take_jump = 1'b0;
        endcase
        pc_next = take_jump ? ir[9:0] : pc + 10'd1;
    end

    // Sequencer state machine with registered write/strobe outputs.
    // Z is sampled on every EXECUTE cycle, including held ones. The last sample wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            z_flag <= 1'b0;
            Sel_C  <= SEL_C_NONE;
            MR     <= 1'b0;
            MW     <= 1'b0;
            halted <= 1'b0;
        end else begin
            if (state == EXECUTE) begin
                z_flag <= Z;
            end
            if (!hold) begin
                unique case (state)
                    FETCH: begin
                        state <= DECODE;
                    end
                    DECODE: begin
                        ir    <= instr;
                        Sel_C <= instr[47:42];
                        MW    <= instr[24];
                        MR    <= instr[25] & ~instr[24];
                        state <= EXECUTE;
                    end
                    EXECUTE: begin
                        Sel_C <= SEL_C_NONE;
                        MR    <= 1'b0;
                        MW    <= 1'b0;
                        state <= NEXT;
                    end
                    NEXT: begin
                        if (ir[21]) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            pc    <= pc_next;
                            state <= FETCH;
                        end
                    end
                    HALT: begin
                        state <= HALT;
                    end
                    default: begin
                        state <= FETCH;
                    end
                endcase
            end
        end
    end

endmodule
